// File: rtl/buzz_score_keeper_pkg.sv
// Shared types and constants for the quiz scoring block and the display views.
// Score helpers do their arithmetic on 8 bits and clamp into the 0..SCORE_MAX range.
package buzz_score_keeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic [6:0] SCORE_MAX    = 7'd99;
    localparam logic [2:0] VIEW_GAME    = 3'd2;
    localparam logic [2:0] VIEW_INSPECT = 3'd3;

    function automatic logic [6:0] score_add(input logic [6:0] cur, input logic [7:0] pts);
        logic [7:0] sum_s;
        sum_s = {1'b0, cur} + pts;
        if (sum_s > {1'b0, SCORE_MAX}) begin
            return SCORE_MAX;
        end else begin
            return sum_s[6:0];
        end
    endfunction

    function automatic logic [6:0] score_sub(input logic [6:0] cur, input logic [7:0] pts);
        logic [7:0] diff_s;
        diff_s = {1'b0, cur} - pts;
        if ({1'b0, cur} < pts) begin
            return 7'd0;
        end else begin
            return diff_s[6:0];
        end
    endfunction

endpackage

// File: rtl/buzz_score_keeper_sec_prescaler.sv
// One-second prescaler: counts clock cycles while enabled and flags the wrap cycle.
// A synchronous clear restarts the second so a fresh answer window is full length.
module buzz_score_keeper_sec_prescaler #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic sec_tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

    logic [CW-1:0] count_r;

    assign sec_tick = en && !clr && (count_r == TERM);

    // cycle counter wrapping at the 1 s terminal count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en) begin
            if (count_r == TERM) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + 1'b1;
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/buzz_score_keeper.sv
// Quiz scoring: buzz-in arbitration, answer countdown and per-player scores.
// The FSM and all score registers live here; the 1 s timebase is a sub-module.
module buzz_score_keeper
    import buzz_score_keeper_pkg::*;
#(
    parameter int         CLK_HZ      = 100_000_000,
    parameter int         ANSWER_SEC  = 10,
    parameter int         CORRECT_PTS = 2,
    parameter int         WRONG_PTS   = 1,
    parameter logic [2:0] GAME_VIEW   = VIEW_GAME
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] view,
    input  logic [2:0] player_count,
    input  logic [3:0] player_bt,
    input  logic       host_correct,
    input  logic       host_wrong,
    input  logic       host_clear,
    output logic [6:0] player1_score,
    output logic [6:0] player2_score,
    output logic [6:0] player3_score,
    output logic [6:0] player4_score,
    output logic [2:0] answering,
    output logic [4:0] time_left,
    output logic       locked,
    output logic       buzzer
);

    state_e     state_r, state_nxt_s;
    logic [6:0] score_r     [4];
    logic [6:0] score_nxt_s [4];
    logic [2:0] answering_r, answering_nxt_s;
    logic [4:0] time_left_r, time_left_nxt_s;
    logic       locked_r, buzzer_r, buzzer_nxt_s;
    logic       sec_tick_s, timeout_s, judge_s;
    logic [3:0] valid_bt_s;
    logic [2:0] first_s;

    buzz_score_keeper_sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_r != ST_LOCKED),
        .en       (state_r == ST_LOCKED),
        .sec_tick (sec_tick_s)
    );

    assign timeout_s = sec_tick_s && (time_left_r == 5'd1);
    assign judge_s   = host_correct || host_wrong || timeout_s;

    // mask buzzes to seated players and pick the lowest-numbered one
    always_comb begin
        valid_bt_s = 4'b0000;
        first_s    = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (player_bt[i] && (3'(i + 1) <= player_count)) begin
                valid_bt_s[i] = 1'b1;
            end else begin
                valid_bt_s[i] = 1'b0;
            end
        end
        for (int i = 3; i >= 0; i--) begin
            if (valid_bt_s[i]) begin
                first_s = 3'(i + 1);
            end else begin
                first_s = first_s;
            end
        end
    end

    // next-state, countdown and score update
    always_comb begin
        state_nxt_s     = state_r;
        answering_nxt_s = answering_r;
        time_left_nxt_s = time_left_r;
        buzzer_nxt_s    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            score_nxt_s[i] = score_r[i];
        end
        if (view != GAME_VIEW) begin
            state_nxt_s     = ST_IDLE;
            answering_nxt_s = 3'd0;
            time_left_nxt_s = 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s     = ST_ARMED;
                    answering_nxt_s = 3'd0;
                    time_left_nxt_s = 5'd0;
                end
                ST_ARMED: begin
                    if (host_clear) begin
                        for (int i = 0; i < 4; i++) begin
                            score_nxt_s[i] = 7'd0;
                        end
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            score_nxt_s[i] = score_r[i];
                        end
                    end
                    if (first_s != 3'd0) begin
                        answering_nxt_s = first_s;
                        time_left_nxt_s = 5'(ANSWER_SEC);
                        buzzer_nxt_s    = 1'b1;
                        state_nxt_s     = ST_LOCKED;
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_LOCKED: begin
                    if (judge_s) begin
                        // a host judgement overrides a coincident timeout
                        for (int i = 0; i < 4; i++) begin
                            if (answering_r == 3'(i + 1)) begin
                                if (host_correct) begin
                                    score_nxt_s[i] = score_add(score_r[i], 8'(CORRECT_PTS));
                                end else begin
                                    score_nxt_s[i] = score_sub(score_r[i], 8'(WRONG_PTS));
                                end
                            end else begin
                                score_nxt_s[i] = score_r[i];
                            end
                        end
                        buzzer_nxt_s    = timeout_s && !host_correct && !host_wrong;
                        answering_nxt_s = 3'd0;
                        time_left_nxt_s = 5'd0;
                        state_nxt_s     = ST_ARMED;
                    end else if (sec_tick_s) begin
                        time_left_nxt_s = time_left_r - 5'd1;
                    end else begin
                        time_left_nxt_s = time_left_r;
                    end
                end
                default: begin
                    state_nxt_s     = ST_IDLE;
                    answering_nxt_s = 3'd0;
                    time_left_nxt_s = 5'd0;
                end
            endcase
        end
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            answering_r <= 3'd0;
            time_left_r <= 5'd0;
            locked_r    <= 1'b0;
            buzzer_r    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                score_r[i] <= 7'd0;
            end
        end else begin
            state_r     <= state_nxt_s;
            answering_r <= answering_nxt_s;
            time_left_r <= time_left_nxt_s;
            locked_r    <= (state_nxt_s == ST_LOCKED);
            buzzer_r    <= buzzer_nxt_s;
            for (int i = 0; i < 4; i++) begin
                score_r[i] <= score_nxt_s[i];
            end
        end
    end

    assign player1_score = score_r[0];
    assign player2_score = score_r[1];
    assign player3_score = score_r[2];
    assign player4_score = score_r[3];
    assign answering     = answering_r;
    assign time_left     = time_left_r;
    assign locked        = locked_r;
    assign buzzer        = buzzer_r;

endmodule

// File: tb/tb_buzz_score_keeper.sv
// Self-checking bench for buzz_score_keeper with a cycle-level behavioural model.
module tb_buzz_score_keeper;

    localparam int CLK_HZ     = 10;
    localparam int ANSWER_SEC = 3;
    localparam int CP         = 2;
    localparam int WP         = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] view, player_count, answering;
    logic [3:0] player_bt;
    logic       host_correct, host_wrong, host_clear, locked, buzzer;
    logic [6:0] p1, p2, p3, p4;
    logic [4:0] time_left;

    int errors = 0;
    int checks = 0;

    // model: scores, who holds the floor, cycles since the buzz
    int m_score [4];
    int m_floor;
    bit m_in_game;
    int m_elapsed;
    bit m_buzz;

    always #5 clk = ~clk;

    buzz_score_keeper #(.CLK_HZ(CLK_HZ), .ANSWER_SEC(ANSWER_SEC), .CORRECT_PTS(CP),
                        .WRONG_PTS(WP), .GAME_VIEW(3'd2)) dut (
        .clk(clk), .rst(rst), .view(view), .player_count(player_count),
        .player_bt(player_bt), .host_correct(host_correct), .host_wrong(host_wrong),
        .host_clear(host_clear), .player1_score(p1), .player2_score(p2),
        .player3_score(p3), .player4_score(p4), .answering(answering),
        .time_left(time_left), .locked(locked), .buzzer(buzzer)
    );

    function automatic logic [6:0] dut_score(input int i);
        case (i)
            0: return p1;
            1: return p2;
            2: return p3;
            default: return p4;
        endcase
    endfunction

    function automatic int m_time_left();
        return (m_floor != 0) ? ANSWER_SEC - m_elapsed / CLK_HZ : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_score[i] = 0;
        m_floor = 0; m_in_game = 0; m_elapsed = 0; m_buzz = 0;
    endtask

    task automatic model_step();
        bit timeout;
        m_buzz = 0;
        if (view != 3'd2) begin
            m_in_game = 0; m_floor = 0; m_elapsed = 0;
        end else if (!m_in_game) begin
            m_in_game = 1;
        end else if (m_floor == 0) begin
            if (host_clear) for (int i = 0; i < 4; i++) m_score[i] = 0;
            for (int i = 4; i >= 1; i--)
                if (player_bt[i-1] && i <= int'(player_count)) m_floor = i;
            if (m_floor != 0) begin
                m_elapsed = 0; m_buzz = 1;
            end
        end else begin
            m_elapsed++;
            timeout = (m_elapsed >= ANSWER_SEC * CLK_HZ);
            if (host_correct) begin
                m_score[m_floor-1] = (m_score[m_floor-1] + CP > 99) ? 99 : m_score[m_floor-1] + CP;
                m_floor = 0;
            end else if (host_wrong || timeout) begin
                m_score[m_floor-1] = (m_score[m_floor-1] < WP) ? 0 : m_score[m_floor-1] - WP;
                m_buzz = timeout && !host_wrong;
                m_floor = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        player_bt = 4'd0; host_correct = 1'b0; host_wrong = 1'b0; host_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; view = 3'd0; player_count = 3'd4; player_bt = 4'd0;
        host_correct = 1'b0; host_wrong = 1'b0; host_clear = 1'b0;
        model_reset();
        #12;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut_score(i) !== 7'd0) begin
                errors++; $display("FAIL reset_score%0d: got %0d expected 0", i + 1, dut_score(i));
            end
        end
        checks++;
        if ({answering, time_left, locked, buzzer} !== 10'd0) begin
            errors++; $display("FAIL reset_outputs: got ans=%0d tl=%0d lk=%0d bz=%0d expected all 0",
                                answering, time_left, locked, buzzer);
        end
        rst = 1'b1;
    endtask

    task automatic test_buzz_priority();
        view = 3'd2; player_count = 3'd4;
        step();
        player_bt = 4'b0110;
        step();
        checks++;
        if (answering !== 3'd2 || locked !== 1'b1 || time_left !== 5'(ANSWER_SEC) || buzzer !== 1'b1) begin
            errors++; $display("FAIL buzz_lock: got ans=%0d lk=%0d tl=%0d bz=%0d expected 2 1 %0d 1",
                                answering, locked, time_left, buzzer, ANSWER_SEC);
        end
        step();
        checks++;
        if (buzzer !== 1'b0) begin
            errors++; $display("FAIL buzz_pulse_width: got %0d expected 0", buzzer);
        end
    endtask

    task automatic test_correct_saturation();
        host_correct = 1'b1;
        step();
        checks++;
        if (p2 !== 7'd2 || answering !== 3'd0 || locked !== 1'b0) begin
            errors++; $display("FAIL first_correct: got p2=%0d ans=%0d lk=%0d expected 2 0 0", p2, answering, locked);
        end
        for (int k = 0; k < 49; k++) begin
            player_bt = 4'b0010; step();
            host_correct = 1'b1; step();
            checks++;
            if (p2 !== 7'(m_score[1])) begin
                errors++; $display("FAIL correct_ramp: got %0d expected %0d", p2, m_score[1]);
            end
        end
        checks++;
        if (p2 !== 7'd99) begin
            errors++; $display("FAIL saturate_99: got %0d expected 99", p2);
        end
    endtask

    task automatic test_invalid_player();
        player_count = 3'd2; player_bt = 4'b1000;
        step();
        checks++;
        if (locked !== 1'b0 || answering !== 3'd0) begin
            errors++; $display("FAIL invalid_buzz: got lk=%0d ans=%0d expected 0 0", locked, answering);
        end
        player_bt = 4'b0001; step();
        host_wrong = 1'b1; step();
        checks++;
        if (p1 !== 7'd0) begin
            errors++; $display("FAIL wrong_floor_0: got %0d expected 0", p1);
        end
    endtask

    task automatic test_timeout();
        player_count = 3'd4;
        for (int k = 0; k < 4; k++) begin
            player_bt = 4'b0100; step();
            if (k < 3) host_correct = 1'b1; else host_wrong = 1'b1;
            step();
        end
        checks++;
        if (p3 !== 7'd5) begin
            errors++; $display("FAIL timeout_setup: got %0d expected 5", p3);
        end
        player_bt = 4'b0100; step();
        for (int k = 1; k <= ANSWER_SEC * CLK_HZ; k++) begin
            step();
            checks++;
            if (time_left !== 5'(m_time_left()) || buzzer !== m_buzz) begin
                errors++; $display("FAIL countdown_c%0d: got tl=%0d bz=%0d expected %0d %0d",
                                    k, time_left, buzzer, m_time_left(), m_buzz);
            end
        end
        checks++;
        if (p3 !== 7'd4 || buzzer !== 1'b1 || locked !== 1'b0) begin
            errors++; $display("FAIL timeout_penalty: got p3=%0d bz=%0d lk=%0d expected 4 1 0", p3, buzzer, locked);
        end
    endtask

    task automatic test_view_leave();
        int prev;
        player_bt = 4'b0001; step();
        view = 3'd3; step();
        checks++;
        if (locked !== 1'b0 || answering !== 3'd0 || p1 !== 7'(m_score[0])) begin
            errors++; $display("FAIL view_leave: got lk=%0d ans=%0d p1=%0d expected 0 0 %0d",
                                locked, answering, p1, m_score[0]);
        end
        view = 3'd2; step();
        player_bt = 4'b0001; step();
        checks++;
        if (answering !== 3'd1 || locked !== 1'b1) begin
            errors++; $display("FAIL rearm_after_view: got ans=%0d lk=%0d expected 1 1", answering, locked);
        end
        prev = m_score[0];
        host_correct = 1'b1; host_wrong = 1'b1; step();
        checks++;
        if (p1 !== 7'(prev + CP)) begin
            errors++; $display("FAIL correct_beats_wrong: got %0d expected %0d", p1, prev + CP);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            view         = ($urandom_range(0, 24) == 0) ? 3'd3 : 3'd2;
            if ($urandom_range(0, 9) == 0) player_count = 3'($urandom_range(2, 4));
            player_bt    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            host_correct = ($urandom_range(0, 7) == 0);
            host_wrong   = ($urandom_range(0, 7) == 0);
            host_clear   = ($urandom_range(0, 15) == 0);
            step();
            checks++;
            if (p1 !== 7'(m_score[0]) || p2 !== 7'(m_score[1]) || p3 !== 7'(m_score[2]) ||
                p4 !== 7'(m_score[3]) || answering !== 3'(m_floor) || locked !== (m_floor != 0) ||
                time_left !== 5'(m_time_left()) || buzzer !== m_buzz) begin
                errors++;
                $display("FAIL random_c%0d: got s=%0d,%0d,%0d,%0d ans=%0d lk=%0d tl=%0d bz=%0d expected s=%0d,%0d,%0d,%0d ans=%0d tl=%0d bz=%0d",
                         k, p1, p2, p3, p4, answering, locked, time_left, buzzer,
                         m_score[0], m_score[1], m_score[2], m_score[3], m_floor, m_time_left(), m_buzz);
            end
        end
    endtask

    task automatic test_async_reset();
        view = 3'd2; player_count = 3'd4;
        step(); step();
        player_bt = 4'b0010; step();
        #2 rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({p1, p2, p3, p4} !== 28'd0 || answering !== 3'd0 || locked !== 1'b0) begin
            errors++; $display("FAIL async_reset: got s=%0d,%0d,%0d,%0d ans=%0d lk=%0d expected all 0",
                                p1, p2, p3, p4, answering, locked);
        end
        #2 rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_buzz_priority();
        test_correct_saturation();
        test_invalid_player();
        test_timeout();
        test_view_leave();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
